// File: rtl/round_pipe_if.sv
// Valid/ready bus for round_pipe: the producer beat in, the rounded result out.
// The master modport is the side feeding operands and consuming results.
interface round_pipe_if #(
    parameter int MAN_WD = 23,
    parameter int EXP_WD = 8,
    parameter int GRD_WD = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic [EXP_WD-1:0]        in_exp;
    logic [MAN_WD+GRD_WD:0]   in_man;
    logic [1:0]               in_rm;

    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sign;
    logic [EXP_WD-1:0]        out_exp;
    logic [MAN_WD-1:0]        out_man;
    logic                     out_inexact;
    logic                     out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_man, in_rm, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, in_rm, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_inexact, out_overflow
    );
endinterface

// File: rtl/round_pipe.sv
// Two-stage IEEE-style rounder: S1 decides the increment, S2 adds, renormalises
// and resolves overflow. Elastic valid/ready handshake at both ends.
module round_pipe #(
    parameter int MAN_WD = 23,
    parameter int EXP_WD = 8,
    parameter int GRD_WD = 3
) (
    input  logic          CLK,
    input  logic          RST,
    round_pipe_if.slave   bus
);
    localparam int SIG_WD = MAN_WD + 1;
    localparam logic [EXP_WD-1:0] EXP_ONES = '1;
    localparam logic [EXP_WD-1:0] EXP_MAXF = {{(EXP_WD-1){1'b1}}, 1'b0};
    localparam logic [EXP_WD-1:0] EXP_ONE  = {{(EXP_WD-1){1'b0}}, 1'b1};

    logic              run_q;
    logic              s1_adv;
    logic              s2_adv;
    logic              take;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_WD-1:0] s1_exp_q, s1_exp_d;
    logic [SIG_WD-1:0] s1_sig_q, s1_sig_d;
    logic [1:0]        s1_rm_q, s1_rm_d;
    logic              s1_inc_q, s1_inc_d;
    logic              s1_inx_q, s1_inx_d;

    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_WD-1:0] out_exp_q, out_exp_d;
    logic [MAN_WD-1:0] out_man_q, out_man_d;
    logic              out_inx_q, out_inx_d;
    logic              out_ovf_q, out_ovf_d;

    logic              lsb_bit, grd_bit, stk_bit;
    logic              inc_c;
    logic [SIG_WD:0]   sum_c;
    logic [EXP_WD-1:0] exp_r;
    logic [MAN_WD-1:0] frac_r;
    logic              to_inf;

    // run_q keeps in_ready low while reset is held and for no longer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    assign s2_adv       = !out_valid_q | bus.out_ready;
    assign s1_adv       = !s1_valid_q | s2_adv;
    assign bus.in_ready = run_q & s1_adv;
    assign take         = bus.in_valid & bus.in_ready;

    assign lsb_bit = bus.in_man[GRD_WD];
    assign grd_bit = bus.in_man[GRD_WD-1];
    assign stk_bit = |bus.in_man[GRD_WD-2:0];

    always_comb begin
        inc_c = 1'b0;
        case (bus.in_rm)
            2'b00:   inc_c = grd_bit & (stk_bit | lsb_bit);
            2'b01:   inc_c = 1'b0;
            2'b10:   inc_c = !bus.in_sign & (grd_bit | stk_bit);
            default: inc_c = bus.in_sign & (grd_bit | stk_bit);
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        s1_rm_d    = s1_rm_q;
        s1_inc_d   = s1_inc_q;
        s1_inx_d   = s1_inx_q;
        if (s1_adv) s1_valid_d = take;
        if (take) begin
            s1_sign_d = bus.in_sign;
            s1_exp_d  = bus.in_exp;
            s1_sig_d  = bus.in_man[MAN_WD+GRD_WD:GRD_WD];
            s1_rm_d   = bus.in_rm;
            s1_inc_d  = inc_c;
            s1_inx_d  = grd_bit | stk_bit;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
            s1_rm_q    <= '0;
            s1_inc_q   <= 1'b0;
            s1_inx_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_sig_q   <= s1_sig_d;
            s1_rm_q    <= s1_rm_d;
            s1_inc_q   <= s1_inc_d;
            s1_inx_q   <= s1_inx_d;
        end
    end

    assign sum_c  = {1'b0, s1_sig_q} + {{SIG_WD{1'b0}}, s1_inc_q};
    assign to_inf = (s1_rm_q == 2'b00) | (s1_rm_q == 2'b10 & !s1_sign_q) |
                    (s1_rm_q == 2'b11 & s1_sign_q);

    // Stage-2 datapath: carry handling, subnormal promotion, then overflow.
    always_comb begin
        exp_r  = s1_exp_q;
        frac_r = sum_c[MAN_WD-1:0];
        if (sum_c[SIG_WD]) begin
            exp_r  = s1_exp_q + EXP_ONE;
            frac_r = '0;
        end else if (s1_exp_q == '0 && !s1_sig_q[MAN_WD] && sum_c[MAN_WD]) begin
            exp_r = EXP_ONE;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_inx_d   = out_inx_q;
        out_ovf_d   = out_ovf_q;
        if (s2_adv) out_valid_d = s1_valid_q;
        if (s2_adv && s1_valid_q) begin
            out_sign_d = s1_sign_q;
            if (s1_exp_q == EXP_ONES) begin
                // Inf/NaN: the payload is carried through untouched.
                out_exp_d = EXP_ONES;
                out_man_d = s1_sig_q[MAN_WD-1:0];
                out_inx_d = 1'b0;
                out_ovf_d = 1'b0;
            end else if (exp_r == EXP_ONES) begin
                out_ovf_d = 1'b1;
                out_inx_d = 1'b1;
                out_exp_d = to_inf ? EXP_ONES : EXP_MAXF;
                out_man_d = to_inf ? '0 : '1;
            end else begin
                out_exp_d = exp_r;
                out_man_d = frac_r;
                out_inx_d = s1_inx_q;
                out_ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_inx_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_inx_q   <= out_inx_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_sign     = out_sign_q;
    assign bus.out_exp      = out_exp_q;
    assign bus.out_man      = out_man_q;
    assign bus.out_inexact  = out_inx_q;
    assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_round_pipe.sv
// Scoreboard bench for round_pipe: expected results are queued as beats are
// accepted and compared when the DUT hands a result over.
module tb_round_pipe;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
        logic        inexact;
        logic        ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   xfer_cnt = 0;
    bit   rnd_bp   = 0;
    res_t exp_q[$];

    round_pipe_if #(.MAN_WD(23), .EXP_WD(8), .GRD_WD(3)) bus ();

    round_pipe #(.MAN_WD(23), .EXP_WD(8), .GRD_WD(3)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t mk_res(input logic s, input logic [7:0] e, input logic [22:0] f,
                                    input logic inx, input logic ovf);
        res_t r;
        r.sign = s; r.exp = e; r.man = f; r.inexact = inx; r.ovf = ovf;
        return r;
    endfunction

    // Reference rounding written in integer arithmetic on the significand.
    function automatic res_t model(input logic s, input logic [7:0] e, input logic [26:0] m,
                                   input logic [1:0] rm);
        res_t        r;
        int unsigned sig, sig2, g, up;
        int          ee;
        bit          to_inf;
        sig = int'(m[26:3]);
        g   = int'(m[2:0]);
        r.sign = s;
        if (e == 8'hFF) begin
            r.exp = e; r.man = m[25:3]; r.inexact = 1'b0; r.ovf = 1'b0;
            return r;
        end
        case (rm)
            2'd0:    up = ((g > 4) || (g == 4 && (sig % 2) == 1)) ? 1 : 0;
            2'd1:    up = 0;
            2'd2:    up = (!s && g != 0) ? 1 : 0;
            default: up = (s && g != 0) ? 1 : 0;
        endcase
        sig2 = sig + up;
        ee   = int'(e);
        if (sig2 >= (1 << 24)) begin
            ee++;
            sig2 = 0;
        end else if (e == 8'h00 && sig < (1 << 23) && sig2 >= (1 << 23)) begin
            ee = 1;
        end
        r.inexact = (g != 0);
        r.ovf     = 1'b0;
        r.exp     = 8'(ee);
        r.man     = 23'(sig2);
        if (ee == 255) begin
            to_inf    = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
            r.ovf     = 1'b1;
            r.inexact = 1'b1;
            r.exp     = to_inf ? 8'hFF : 8'hFE;
            r.man     = to_inf ? 23'h0 : 23'h7FFFFF;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [1:0] rm, input res_t expv);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_man   = m;
        bus.in_rm    = rm;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(expv);
                tick();
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", 1, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        res_t e, o;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            o = mk_res(bus.out_sign, bus.out_exp, bus.out_man, bus.out_inexact, bus.out_overflow);
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                xfer_cnt++;
                $display("out %0d: s=%0d exp=%02h man=%06h inx=%0d ovf=%0d", xfer_cnt,
                         o.sign, o.exp, o.man, o.inexact, o.ovf);
                check("result", 64'(o), 64'(e));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [26:0] m;
        logic [1:0]  rm;
        int          acc;
        logic [26:0] bp_man [4];
        res_t        bp_exp [4];

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
        bus.in_man = '0; bus.in_rm = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 0);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_out_bus", 64'({bus.out_sign, bus.out_exp, bus.out_man,
                                  bus.out_inexact, bus.out_overflow}), 0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(bus.in_ready), 1);

        // Latency: accepted at edge N -> valid after edge N+1.
        send(0, 8'h80, {1'b1, 23'h000001, 3'b100}, 2'd0, mk_res(0, 8'h80, 23'h000002, 1, 0));
        check("lat_n", 64'(bus.out_valid), 0);
        tick();
        check("lat_n1", 64'(bus.out_valid), 1);
        drain();

        send(0, 8'h80, {1'b1, 23'h000000, 3'b100}, 2'd0, mk_res(0, 8'h80, 23'h000000, 1, 0));
        send(0, 8'h80, {1'b1, 23'h7FFFFF, 3'b110}, 2'd0, mk_res(0, 8'h81, 23'h000000, 1, 0));
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b111}, 2'd0, mk_res(0, 8'hFF, 23'h000000, 1, 1));
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b111}, 2'd1, mk_res(0, 8'hFE, 23'h7FFFFF, 1, 0));
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b111}, 2'd3, mk_res(0, 8'hFE, 23'h7FFFFF, 1, 0));
        send(1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b111}, 2'd2, mk_res(1, 8'hFE, 23'h7FFFFF, 1, 0));
        send(1, 8'h80, {1'b1, 23'h000010, 3'b001}, 2'd3, mk_res(1, 8'h80, 23'h000011, 1, 0));
        send(0, 8'h80, {1'b1, 23'h000010, 3'b001}, 2'd3, mk_res(0, 8'h80, 23'h000010, 1, 0));
        send(0, 8'h80, {1'b1, 23'h000010, 3'b001}, 2'd2, mk_res(0, 8'h80, 23'h000011, 1, 0));
        for (int k = 0; k < 4; k++)
            send(k[0], 8'h80, {1'b1, 23'h000010, 3'b000}, 2'(k),
                 mk_res(k[0], 8'h80, 23'h000010, 0, 0));
        send(0, 8'h00, {1'b0, 23'h7FFFFF, 3'b110}, 2'd0, mk_res(0, 8'h01, 23'h000000, 1, 0));
        send(1, 8'hFF, {1'b1, 23'h400001, 3'b111}, 2'd2, mk_res(1, 8'hFF, 23'h400001, 0, 0));
        drain();

        // Backpressure: 4 back-to-back beats against a stalled sink.
        for (int k = 0; k < 4; k++) begin
            bp_man[k] = {1'b1, 23'(32'h100 * (k + 1)), 3'b011};
            bp_exp[k] = model(1'b0, 8'h90, bp_man[k], 2'd2);
        end
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            if (c == 4) begin
                check("bp_accepted", 64'(acc), 2);
                check("bp_in_ready", 64'(bus.in_ready), 0);
                bus.out_ready = 1'b1;
            end
            bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'h90;
            bus.in_man = bp_man[acc]; bus.in_rm = 2'd2;
            @(negedge clk);
            if (c == 2 || c == 3) begin
                check("bp_hold_valid", 64'(bus.out_valid), 1);
                check("bp_hold_man", 64'(bus.out_man), 64'(bp_exp[0].man));
            end
            if (c >= 4) check("bp_stream", 64'(bus.out_valid), 1);
            if (bus.in_ready) begin
                exp_q.push_back(bp_exp[acc]);
                acc++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_stream_tail", 64'(bus.out_valid), 1);
            tick();
        end
        drain();

        // Random traffic with random sink stalls.
        rnd_bp = 1;
        for (int n = 0; n < 200; n++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       e = 8'h00;
                1:       e = 8'hFE;
                2:       e = 8'hFF;
                default: e = 8'($urandom_range(1, 253));
            endcase
            f = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
            m = {(e == 8'h00) ? 1'($urandom_range(0, 1)) : 1'b1, f, 3'($urandom_range(0, 7))};
            rm = 2'($urandom_range(0, 3));
            r = model(s, e, m, rm);
            send(s, e, m, rm, r);
        end
        rnd_bp = 0;
        drain();

        // Reset with both stages occupied.
        bus.out_ready = 1'b0;
        send(0, 8'h80, {1'b1, 23'h000001, 3'b100}, 2'd0, mk_res(0, 8'h80, 23'h000002, 1, 0));
        send(0, 8'h81, {1'b1, 23'h000002, 3'b100}, 2'd0, mk_res(0, 8'h81, 23'h000002, 1, 0));
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(bus.out_valid), 0);
            tick();
        end
        send(1, 8'h40, {1'b1, 23'h000004, 3'b010}, 2'd3, mk_res(1, 8'h40, 23'h000005, 1, 0));
        check("post_rst_lat_n", 64'(bus.out_valid), 0);
        tick();
        check("post_rst_lat_n1", 64'(bus.out_valid), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 SHALL have parameter MAN_WD, default 23, stored fraction width (hidden bit excluded).
REQ-002 SHALL have parameter EXP_WD, default 8, biased exponent width.
REQ-003 SHALL have parameter GRD_WD, default 3, extra bits below LSB (guard, round, sticky...), minimum 2.
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_sign  input  1  operand sign.
REQ-009 SHALL have port in_exp  input  EXP_WD  biased exponent.
REQ-010 SHALL have port in_man  input  MAN_WD+1+GRD_WD  {hidden, fraction, guard field}.
REQ-011 SHALL have port in_rm  input  2  round mode: 00 nearest-even, 01 zero, 10 +inf, 11 -inf.
REQ-012 SHALL have port out_valid  output  1  result beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have ports out_sign (1), out_exp (EXP_WD), out_man (MAN_WD)  outputs  rounded result, fraction only.
REQ-015 SHALL have ports out_inexact, out_overflow  outputs  1 each  per-result IEEE flags.

Function
REQ-016 Transfer SHALL occur on a rising edge where valid and ready are both 1, on either side.
REQ-017 Pipeline SHALL be two registered stages: S1 computes increment decision; S2 performs add, renormalisation, overflow handling; all outputs driven from S2 registers.
REQ-018 Latency SHALL be 2 cycles: beat accepted at edge N appears with out_valid=1 after edge N+1, transfers at edge N+2 when out_ready=1; throughput 1 beat/cycle.
REQ-019 A stage SHALL advance when it is empty or the next stage advances; in_ready = !S1_valid | S1_advance; S2 advances when !out_valid | out_ready.
REQ-020 While out_valid=1 and out_ready=0, all out_* SHALL hold stable; no beat SHALL be dropped, duplicated or reordered.
REQ-021 Definitions: L = in_man[GRD_WD]; G = in_man[GRD_WD-1]; S = OR of in_man[GRD_WD-2:0].
REQ-022 Increment SHALL be: RNE G&(S|L); RZ 0; R+inf !sign&(G|S); R-inf sign&(G|S).
REQ-023 out_inexact SHALL equal G|S for finite inputs.
REQ-024 Sum {hidden,fraction}+inc SHALL be MAN_WD+2 bits wide; on carry-out, fraction SHALL become 0 and exponent SHALL increment by 1.
REQ-025 With in_exp=0 and hidden=0 (subnormal), a carry into the hidden bit SHALL set exponent to 1 with fraction 0.
REQ-026 If the rounded exponent reaches all-ones, out_overflow=1 and out_inexact=1; result SHALL be infinity (exp all-ones, fraction 0) for RNE, for R+inf when sign=0, for R-inf when sign=1; otherwise max finite (exp all-ones minus 1, fraction all-ones).
REQ-027 in_exp all-ones (Inf/NaN) SHALL pass through unchanged: fraction = in_man[MAN_WD+GRD_WD-1:GRD_WD], flags 0.
REQ-028 out_sign SHALL equal in_sign for all cases.

Reset
REQ-029 RST=0 SHALL asynchronously clear S1/S2 valid bits and all out_* to 0; in_ready SHALL be 0 while RST=0 and 1 the first cycle after release.
REQ-030 Beats in flight at reset assertion SHALL be discarded; no out_valid pulse SHALL follow release without a new input.

Verification (MAN_WD=23, EXP_WD=8, GRD_WD=3, out_ready=1 unless stated)
REQ-031 RNE ties: exp 0x80, fraction 0x000001, guard 100 -> fraction 0x000002, inexact 1; fraction 0x000000, guard 100 -> fraction 0x000000, inexact 1.
REQ-032 Carry: exp 0x80, fraction 0x7FFFFF, guard 110, RNE -> exp 0x81, fraction 0, overflow 0, inexact 1.
REQ-033 Overflow: exp 0xFE, fraction 0x7FFFFF, guard 111: RNE -> exp 0xFF fraction 0 overflow 1; RZ -> exp 0xFE fraction 0x7FFFFF overflow 0 inexact 1; R-inf sign 0 -> 0xFE/0x7FFFFF overflow 0.
REQ-034 Directed modes: fraction 0x000010, guard 001: R-inf sign 1 -> 0x000011; R-inf sign 0 -> 0x000010; R+inf sign 0 -> 0x000011; guard 000 any mode -> unchanged, inexact 0.
REQ-035 Backpressure: 4 back-to-back beats with out_ready=0 -> exactly 2 accepted, in_ready=0, first result held stable; raise out_ready -> all 4 delivered in order, one per cycle, none lost.
REQ-036 Reset mid-stream: assert RST with both stages full -> out_valid=0 immediately (no clock), in_ready=0; after release in_ready=1, no output until new beat, which appears 2 cycles later.
